// File: rtl/orpsoc_top_system.sv
// orpsoc_top_system: reset conditioner, word-addressed program RAM and a
// JTAG TAP oversampled on wb_clk_i with a memory-access debug register.

// Single-port RAM with write on the rising edge and a combinational read.
module orpsoc_ram #(
    parameter int MEM_WORDS = 8192,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    // Not cleared by reset so images loaded before or during reset survive.
    reg [31:0] mem [0:MEM_WORDS-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// Wrapper keeping the memory reachable as mem.ram0.mem from the top.
module orpsoc_mem #(
    parameter int MEM_WORDS = 8192,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    orpsoc_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) ram0 (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule

// TAP states:
//   TLR              | test-logic-reset, IR forced to IDCODE
//   RTI              | run-test/idle
//   SEL_DR / SEL_IR  | select DR / IR scan branch
//   CAP_DR / CAP_IR  | load the selected register on leaving
//   SH_DR  / SH_IR   | shift one bit per TCK rise
//   EX1_*  / EX2_*   | exit states around pause
//   PAU_DR / PAU_IR  | hold shift register contents
//   UPD_DR / UPD_IR  | entered: apply DR (memory access) / latch IR
module orpsoc_top_system #(
    parameter int          MEM_WORDS = 8192,
    parameter logic [31:0] IDCODE    = 32'h14951185
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic tck_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o
);
    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] IR_IDCODE = 4'h2;
    localparam logic [3:0] IR_DEBUG  = 4'h8;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    logic       wb_rst;
    logic       tck_meta, tck_sync, tck_prev;
    logic       tms_meta, tms_sync;
    logic       tdi_meta, tdi_sync;
    logic       tck_rise, tck_fall;

    tap_state_t state_q, state_d;
    logic       ir_capture, ir_shift, ir_update;
    logic       dr_capture, dr_shift, dr_update;

    logic [3:0]  ir;
    logic [3:0]  ir_sr;
    logic [31:0] dr_id;
    logic        dr_byp;
    logic [64:0] dr_dbg;
    logic        dr_lsb;

    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] rdata;

    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_in_range;
    logic        dbg_update;
    logic        ram_we;
    logic [31:0] ram_q;
    logic [1:0]  unused_byte_sel;

    // Registered reset; the JTAG driver waits on this signal.
    always_ff @(posedge wb_clk_i) begin
        wb_rst <= wb_rst_i;
    end

    // Two-flop synchronizers for the pads plus a TCK history flop for edges.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            tck_meta <= 1'b0;
            tck_sync <= 1'b0;
            tck_prev <= 1'b0;
            tms_meta <= 1'b0;
            tms_sync <= 1'b0;
            tdi_meta <= 1'b0;
            tdi_sync <= 1'b0;
        end else begin
            tck_meta <= tck_pad_i;
            tck_sync <= tck_meta;
            tck_prev <= tck_sync;
            tms_meta <= tms_pad_i;
            tms_sync <= tms_meta;
            tdi_meta <= tdi_pad_i;
            tdi_sync <= tdi_meta;
        end
    end

    assign tck_rise = tck_sync & ~tck_prev;
    assign tck_fall = ~tck_sync & tck_prev;

    // TAP state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next state and per-rise action strobes.
    always_comb begin
        state_d    = state_q;
        ir_capture = 1'b0;
        ir_shift   = 1'b0;
        ir_update  = 1'b0;
        dr_capture = 1'b0;
        dr_shift   = 1'b0;
        dr_update  = 1'b0;
        if (tck_rise) begin
            unique case (state_q)
                TLR:     state_d = tms_sync ? TLR    : RTI;
                RTI:     state_d = tms_sync ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_sync ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_sync ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_sync ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_sync ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_sync ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_sync ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_sync ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_sync ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_sync ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_sync ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_sync ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_sync ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_sync ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_sync ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
            ir_capture = (state_q == CAP_IR);
            ir_shift   = (state_q == SH_IR);
            dr_capture = (state_q == CAP_DR);
            dr_shift   = (state_q == SH_DR);
            // Update states are never re-entered from themselves, so this is
            // a single-cycle entry strobe.
            ir_update  = (state_d == UPD_IR);
            dr_update  = (state_d == UPD_DR);
        end
    end

    // Instruction register and its shift stage.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            ir    <= IR_IDCODE;
            ir_sr <= 4'h0;
        end else begin
            if (state_q == TLR) begin
                ir <= IR_IDCODE;
            end else if (ir_update) begin
                ir <= ir_sr;
            end
            if (ir_capture) begin
                ir_sr <= 4'b0001;
            end else if (ir_shift) begin
                ir_sr <= {tdi_sync, ir_sr[3:1]};
            end
        end
    end

    // Data registers: capture and shift only the one selected by IR.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            dr_id  <= 32'h0;
            dr_byp <= 1'b0;
            dr_dbg <= 65'h0;
        end else if (dr_capture) begin
            case (ir)
                IR_IDCODE: dr_id  <= IDCODE;
                IR_DEBUG:  dr_dbg <= {last_we, last_addr, rdata};
                default:   dr_byp <= 1'b0;
            endcase
        end else if (dr_shift) begin
            case (ir)
                IR_IDCODE: dr_id  <= {tdi_sync, dr_id[31:1]};
                IR_DEBUG:  dr_dbg <= {tdi_sync, dr_dbg[64:1]};
                default:   dr_byp <= tdi_sync;
            endcase
        end
    end

    // LSB of whichever data register IR selects.
    always_comb begin
        dr_lsb = dr_byp;
        case (ir)
            IR_IDCODE: dr_lsb = dr_id[0];
            IR_DEBUG:  dr_lsb = dr_dbg[0];
            default:   dr_lsb = dr_byp;
        endcase
    end

    // TDO changes on TCK fall so the host can sample it on the next rise.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            tdo_pad_o <= 1'b0;
        end else if (tck_fall) begin
            if (state_q == SH_IR) begin
                tdo_pad_o <= ir_sr[0];
            end else if (state_q == SH_DR) begin
                tdo_pad_o <= dr_lsb;
            end else begin
                tdo_pad_o <= 1'b0;
            end
        end
    end

    assign dbg_we          = dr_dbg[64];
    assign dbg_addr        = dr_dbg[63:32];
    assign dbg_data        = dr_dbg[31:0];
    assign unused_byte_sel = dbg_addr[1:0];
    assign dbg_in_range    = (dbg_addr[31:2] < 30'(MEM_WORDS));
    assign dbg_update      = dr_update && (ir == IR_DEBUG) && !wb_rst;
    assign ram_we          = dbg_update && dbg_we && dbg_in_range;

    // Debug access bookkeeping; reads land in rdata for the next capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst) begin
            last_we   <= 1'b0;
            last_addr <= 32'h0;
            rdata     <= 32'h0;
        end else if (dbg_update) begin
            last_we   <= dbg_we;
            last_addr <= dbg_addr;
            if (!dbg_we) begin
                rdata <= dbg_in_range ? ram_q : 32'h0;
            end
        end
    end

    orpsoc_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) mem (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .addr  (dbg_addr[AW+1:2]),
        .wdata (dbg_data),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_orpsoc_top_system.sv
// Bench for orpsoc_top_system: bit-banged JTAG host plus a memory/debug model.
module tb_orpsoc_top_system;
    localparam int          MEM_WORDS = 8192;
    localparam logic [31:0] IDCODE    = 32'h14951185;

    logic wb_clk_i  = 1'b0;
    logic wb_rst_i  = 1'b1;
    logic tck_pad_i = 1'b0;
    logic tms_pad_i = 1'b1;
    logic tdi_pad_i = 1'b0;
    logic tdo_pad_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the memory holds and what the next debug capture shows.
    logic [31:0] m_mem [int];
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    int          pre_idx[$];

    always #5 wb_clk_i = ~wb_clk_i;

    orpsoc_top_system #(
        .MEM_WORDS (MEM_WORDS),
        .IDCODE    (IDCODE)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .tck_pad_i (tck_pad_i),
        .tms_pad_i (tms_pad_i),
        .tdi_pad_i (tdi_pad_i),
        .tdo_pad_o (tdo_pad_o)
    );

    function automatic logic [64:0] model_capture();
        return {m_we, m_addr, m_rdata};
    endfunction

    function automatic void model_apply(logic we, logic [31:0] addr, logic [31:0] data);
        int idx;
        idx    = int'(addr >> 2);
        m_we   = we;
        m_addr = addr;
        if (idx < MEM_WORDS) begin
            if (we) m_mem[idx] = data;
            else    m_rdata = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        end else if (!we) begin
            m_rdata = 32'h0;
        end
    endfunction

    function automatic void model_reset();
        m_we    = 1'b0;
        m_addr  = 32'h0;
        m_rdata = 32'h0;
    endfunction

    // One TCK period: sample TDO, drive TMS/TDI with the rising edge, 4 clocks high, 4 low.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        @(negedge wb_clk_i);
        tdo       = tdo_pad_o;
        tms_pad_i = tms;
        tdi_pad_i = tdi;
        tck_pad_i = 1'b1;
        repeat (4) @(negedge wb_clk_i);
        tck_pad_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
    endtask

    // From RTI: full IR scan, back to RTI.
    task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
        logic b;
        cap = 4'h0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, code[i], b);
            cap[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    // From RTI: full DR scan of width bits, back to RTI.
    task automatic shift_dr(input int width, input logic [64:0] din, output logic [64:0] dout);
        logic b;
        dout = 65'h0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < width; i++) begin
            tck_cycle(i == width - 1, din[i], b);
            dout[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic dbg_scan(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            output logic [64:0] cap);
        shift_dr(65, {we, addr, data}, cap);
    endtask

    task automatic test_reset();
        logic b;
        repeat (3) @(negedge wb_clk_i);
        dut.mem.ram0.mem[0] = 32'h12345678;
        m_mem[0] = 32'h12345678;
        n_checks++;
        if (dut.wb_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wb_rst: got %b expected 1", dut.wb_rst);
        end
        n_checks++;
        if (tdo_pad_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tdo: got %b expected 0", tdo_pad_o);
        end
        repeat (7) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        n_checks++;
        if (dut.wb_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL release_wb_rst: got %b expected 0", dut.wb_rst);
        end
        n_checks++;
        if (dut.mem.ram0.mem[0] !== m_mem[0]) begin
            n_fail++;
            $display("FAIL reset_preload_kept: got %h expected %h", dut.mem.ram0.mem[0], m_mem[0]);
        end
        model_reset();
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic test_idcode();
        logic [64:0] dout;
        shift_dr(32, 65'h0, dout);
        n_checks++;
        if (dout[31:0] !== IDCODE) begin
            n_fail++;
            $display("FAIL idcode: got %h expected %h", dout[31:0], IDCODE);
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  cap;
        logic [64:0] dout;
        logic [15:0] pat;
        shift_ir(4'hF, cap);
        n_checks++;
        if (cap !== 4'b0001) begin
            n_fail++;
            $display("FAIL bypass_ir_capture: got %b expected 0001", cap);
        end
        shift_dr(4, 65'b1101, dout);
        n_checks++;
        if (dout[3:0] !== 4'b1010) begin
            n_fail++;
            $display("FAIL bypass_1011: got %b expected 1010", dout[3:0]);
        end
        pat = 16'($urandom);
        shift_dr(16, {49'h0, pat}, dout);
        n_checks++;
        if (dout[15:0] !== {pat[14:0], 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_random: got %h expected %h", dout[15:0], {pat[14:0], 1'b0});
        end
    endtask

    task automatic test_write_read();
        logic [3:0]  cap;
        logic [64:0] dout, exp;
        shift_ir(4'h8, cap);
        n_checks++;
        if (cap !== 4'b0001) begin
            n_fail++;
            $display("FAIL debug_ir_capture: got %b expected 0001", cap);
        end
        exp = model_capture();
        dbg_scan(1'b1, 32'h100, 32'hDEADBEEF, dout);
        model_apply(1'b1, 32'h100, 32'hDEADBEEF);
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL wr_capture0: got %h expected %h", dout, exp);
        end
        n_checks++;
        if (dut.mem.ram0.mem[64] !== m_mem[64]) begin
            n_fail++;
            $display("FAIL wr_mem64: got %h expected %h", dut.mem.ram0.mem[64], m_mem[64]);
        end
        exp = model_capture();
        dbg_scan(1'b0, 32'h100, 32'h0, dout);
        model_apply(1'b0, 32'h100, 32'h0);
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL wr_capture1: got %h expected %h", dout, exp);
        end
        exp = model_capture();
        dbg_scan(1'b0, 32'h100, 32'h0, dout);
        model_apply(1'b0, 32'h100, 32'h0);
        n_checks++;
        if (dout !== exp || dout[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data: got %h expected %h", dout, exp);
        end
    endtask

    task automatic test_backdoor_preload();
        logic [64:0] dout, exp;
        dbg_scan(1'b0, 32'h0, 32'h0, dout);
        model_apply(1'b0, 32'h0, 32'h0);
        exp = model_capture();
        dbg_scan(1'b0, 32'h0, 32'h0, dout);
        model_apply(1'b0, 32'h0, 32'h0);
        n_checks++;
        if (dout !== exp || dout[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL preload_read: got %h expected %h", dout, exp);
        end
    endtask

    task automatic test_out_of_range();
        logic [64:0] dout, exp;
        logic [31:0] d;
        logic [31:0] oor;
        oor = 32'(MEM_WORDS * 4);
        d   = $urandom;
        exp = model_capture();
        dbg_scan(1'b1, oor, d, dout);
        model_apply(1'b1, oor, d);
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL oor_capture: got %h expected %h", dout, exp);
        end
        n_checks++;
        if (dut.mem.ram0.mem[0] !== m_mem[0]) begin
            n_fail++;
            $display("FAIL oor_no_write: got %h expected %h", dut.mem.ram0.mem[0], m_mem[0]);
        end
        dbg_scan(1'b0, oor, 32'h0, dout);
        model_apply(1'b0, oor, 32'h0);
        exp = model_capture();
        dbg_scan(1'b0, 32'hFFFF_FFFC, 32'h0, dout);
        model_apply(1'b0, 32'hFFFF_FFFC, 32'h0);
        n_checks++;
        if (dout !== exp || dout[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_zero: got %h expected %h", dout, exp);
        end
    endtask

    task automatic test_random();
        logic [64:0] dout, exp;
        logic [31:0] addr, d;
        logic        we;
        int          idx;
        for (int i = 0; i < 8; i++) begin
            idx = 100 + i * 997 + int'($urandom_range(0, 900));
            pre_idx.push_back(idx);
            d = $urandom;
            dut.mem.ram0.mem[idx] = d;
            m_mem[idx] = d;
        end
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                addr = 32'(MEM_WORDS * 4) + ($urandom & 32'h0FFF_FFFF);
            end else begin
                idx  = pre_idx[$urandom_range(0, 7)];
                addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            end
            we  = 1'($urandom);
            d   = $urandom;
            exp = model_capture();
            dbg_scan(we, addr, d, dout);
            model_apply(we, addr, d);
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("FAIL rand_capture[%0d]: got %h expected %h", n, dout, exp);
            end
            if (int'(addr >> 2) < MEM_WORDS) begin
                idx = int'(addr >> 2);
                n_checks++;
                if (dut.mem.ram0.mem[idx] !== m_mem[idx]) begin
                    n_fail++;
                    $display("FAIL rand_mem[%0d]: got %h expected %h", idx, dut.mem.ram0.mem[idx], m_mem[idx]);
                end
            end
        end
    endtask

    task automatic test_tms_reset();
        logic [3:0]  cap;
        logic [64:0] dout;
        logic        b;
        shift_ir(4'hF, cap);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'($urandom), b);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b1, b);
        tck_cycle(1'b0, 1'b0, b);
        shift_dr(32, 65'h0, dout);
        n_checks++;
        if (dout[31:0] !== IDCODE) begin
            n_fail++;
            $display("FAIL tms_reset_idcode: got %h expected %h", dout[31:0], IDCODE);
        end
    endtask

    task automatic test_rst_mid_scan();
        logic [3:0]  cap;
        logic [64:0] dout, exp, din;
        logic        b;
        int          idx;
        logic [31:0] old;
        idx = pre_idx[0];
        old = m_mem[idx];
        din = {1'b1, 32'(idx) << 2, ~old};
        shift_ir(4'h8, cap);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 50; i++) tck_cycle(1'b0, din[i], b);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        model_reset();
        n_checks++;
        if (tdo_pad_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_tdo: got %b expected 0", tdo_pad_o);
        end
        n_checks++;
        if (dut.mem.ram0.mem[idx] !== old) begin
            n_fail++;
            $display("FAIL rst_mid_no_write: got %h expected %h", dut.mem.ram0.mem[idx], old);
        end
        tck_cycle(1'b0, 1'b0, b);
        shift_dr(32, 65'h0, dout);
        n_checks++;
        if (dout[31:0] !== IDCODE) begin
            n_fail++;
            $display("FAIL rst_mid_idcode: got %h expected %h", dout[31:0], IDCODE);
        end
        shift_ir(4'h8, cap);
        exp = model_capture();
        dbg_scan(1'b0, 32'(idx) << 2, 32'h0, dout);
        model_apply(1'b0, 32'(idx) << 2, 32'h0);
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_capture: got %h expected %h", dout, exp);
        end
        exp = model_capture();
        dbg_scan(1'b0, 32'(idx) << 2, 32'h0, dout);
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_readback: got %h expected %h", dout, exp);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_idcode();
        test_bypass();
        test_write_read();
        test_backdoor_preload();
        test_out_of_range();
        test_random();
        test_tms_reset();
        test_rst_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
